// File: rtl/tinyqv_stream_periph.sv
// TinyQV data-bus responder bridging CPU word writes/reads to outbound/inbound valid-ready streams.
// One-cycle minimum access latency; data_ready is withheld while the addressed FIFO is full (TX) or empty (RX).

module stream_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Flush wins over any same-cycle stream transfer: the transfer happens, then the queue is emptied.
    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                mem[wr_ptr] <= push_data;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    assign head = mem[rd_ptr];
endmodule

module tinyqv_stream_periph #(
    parameter logic [27:0] BASE_ADDR = 28'h800_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    output logic        data_ready,
    output logic [31:0] data_in,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready
);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic          wr_req;
    logic          rd_req;
    logic          hit;
    logic [1:0]    sel;
    logic          avail;
    logic          accept;
    logic          tx_full;
    logic          rx_empty;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_flush;
    logic          rx_push;
    logic          rx_pop;
    logic          rx_flush;
    logic [31:0]   wdata;
    logic [31:0]   rd_val;
    logic [31:0]   status;
    logic [31:0]   rx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] tx_count_next;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] rx_count_next;

    assign wr_req   = (data_write_n != 2'b11);
    assign rd_req   = (data_read_n != 2'b11);
    assign hit      = (data_addr[27:4] == BASE_ADDR[27:4]) && (wr_req != rd_req);
    assign sel      = data_addr[3:2];
    assign tx_full  = (tx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);

    always_comb begin
        avail = 1'b1;
        if (wr_req && sel == 2'd0)
            avail = !tx_full;
        if (rd_req && sel == 2'd1)
            avail = !rx_empty;
    end

    // data_ready gates acceptance so a request still held during its completion cycle is not taken twice.
    assign accept   = hit && !data_ready && avail;
    assign tx_push  = accept && wr_req && (sel == 2'd0);
    assign tx_flush = accept && wr_req && (sel == 2'd3) && data_out[0];
    assign rx_pop   = accept && rd_req && (sel == 2'd1);
    assign rx_flush = accept && wr_req && (sel == 2'd3) && data_out[1];
    assign tx_pop   = out_valid && out_ready;
    assign rx_push  = in_valid && in_ready;

    always_comb begin
        case (data_write_n)
            2'b00:   wdata = {24'b0, data_out[7:0]};
            2'b01:   wdata = {16'b0, data_out[15:0]};
            default: wdata = data_out;
        endcase
    end

    always_comb begin
        status      = '0;
        status[3:0] = 4'(tx_count);
        status[11:8] = 4'(rx_count);
        status[16]  = tx_full;
        status[17]  = rx_empty;
    end

    always_comb begin
        rd_val = '0;
        if (rd_req) begin
            case (sel)
                2'd1:    rd_val = rx_head;
                2'd2:    rd_val = status;
                default: rd_val = '0;
            endcase
        end
    end

    stream_fifo #(.DEPTH(DEPTH), .W(32), .CW(CW)) u_tx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (tx_push),
        .push_data  (wdata),
        .pop        (tx_pop),
        .flush      (tx_flush),
        .head       (out_data),
        .count      (tx_count),
        .count_next (tx_count_next)
    );

    stream_fifo #(.DEPTH(DEPTH), .W(32), .CW(CW)) u_rx_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (rx_push),
        .push_data  (in_data),
        .pop        (rx_pop),
        .flush      (rx_flush),
        .head       (rx_head),
        .count      (rx_count),
        .count_next (rx_count_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_ready <= 1'b0;
            data_in    <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            data_ready <= accept;
            if (accept)
                data_in <= rd_val;
            out_valid <= (tx_count_next != '0);
            in_ready  <= (rx_count_next != FULL_CNT);
        end
    end
endmodule
